// File: rtl/alu_result_stage.sv
// ALU result stage: Z capture, zero/neg flags, bus drive and
// two-beat LO/HI writeback for multiply/divide results.
module alu_result_stage #(
  parameter int BITS      = 32,
  parameter int SIG_COUNT = 12
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [SIG_COUNT-1:0]   ctrl_signal,
  input  logic [2*BITS-1:0]      operationResult,
  input  logic                   Zin,
  output logic                   in_ready,
  input  logic                   ZLowout,
  input  logic                   ZHighout,
  output logic [BITS-1:0]        bus_out,
  output logic                   zero_flag,
  output logic                   neg_flag,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic                   wb_sel,
  output logic [BITS-1:0]        wb_data,
  output logic                   busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] WB_LO = 2'd2;
  localparam logic [1:0] WB_HI = 2'd3;

  localparam logic [SIG_COUNT-1:0] OP_MUL = SIG_COUNT'(4);
  localparam logic [SIG_COUNT-1:0] OP_DIV = SIG_COUNT'(8);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [2*BITS-1:0] z;
  logic              is_mul;
  logic              wide;
  logic              cap;
  logic              zf_nx;
  logic              nf_nx;

  assign is_mul = (ctrl_signal == OP_MUL);
  assign wide   = is_mul || (ctrl_signal == OP_DIV);
  assign cap    = Zin && in_ready;

  // Divide keeps the quotient in the low half, so only multiply
  // looks at the full-width result.
  always_comb begin
    zf_nx = (operationResult[BITS-1:0] == '0);
    nf_nx = operationResult[BITS-1];
    if (is_mul) begin
      zf_nx = (operationResult == '0);
      nf_nx = operationResult[2*BITS-1];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, HOLD: if (cap) state_nx = wide ? WB_LO : HOLD;
      WB_LO:      if (wb_ready) state_nx = WB_HI;
      WB_HI:      if (wb_ready) state_nx = HOLD;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      z         <= '0;
      zero_flag <= 1'b0;
      neg_flag  <= 1'b0;
    end else begin
      state <= state_nx;
      if (cap) begin
        z         <= operationResult;
        zero_flag <= zf_nx;
        neg_flag  <= nf_nx;
      end
    end
  end

  assign busy     = (state == WB_LO) || (state == WB_HI);
  assign in_ready = !busy;
  assign wb_valid = busy;
  assign wb_sel   = (state == WB_HI);

  always_comb begin
    wb_data = '0;
    if (state == WB_LO) wb_data = z[BITS-1:0];
    if (state == WB_HI) wb_data = z[2*BITS-1:BITS];
  end

  always_comb begin
    bus_out = '0;
    if (ZLowout)       bus_out = z[BITS-1:0];
    else if (ZHighout) bus_out = z[2*BITS-1:BITS];
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized bench for alu_result_stage against a queue-based
// model of the pending writeback beats.
module tb_alu_result_stage;

  logic        clk;
  logic        clr;
  logic [11:0] ctrl_signal;
  logic [63:0] operationResult;
  logic        Zin;
  logic        in_ready;
  logic        ZLowout;
  logic        ZHighout;
  logic [31:0] bus_out;
  logic        zero_flag;
  logic        neg_flag;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_sel;
  logic [31:0] wb_data;
  logic        busy;

  alu_result_stage #(.BITS(32), .SIG_COUNT(12)) dut (
    .clk(clk), .clr(clr), .ctrl_signal(ctrl_signal),
    .operationResult(operationResult), .Zin(Zin),
    .in_ready(in_ready), .ZLowout(ZLowout), .ZHighout(ZHighout),
    .bus_out(bus_out), .zero_flag(zero_flag), .neg_flag(neg_flag),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_sel(wb_sel),
    .wb_data(wb_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [31:0] data;
  } beat_t;

  beat_t       q[$];
  logic [63:0] m_z;
  logic        m_zf;
  logic        m_nf;
  int          errors;
  int          checks;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp,
               $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] eb;
    logic        pend;
    pend = (q.size() != 0);
    eb = 32'd0;
    if (ZLowout)       eb = m_z[31:0];
    else if (ZHighout) eb = m_z[63:32];
    chk("bus_out", 64'(bus_out), 64'(eb));
    chk("zero_flag", 64'(zero_flag), 64'(m_zf));
    chk("neg_flag", 64'(neg_flag), 64'(m_nf));
    chk("in_ready", 64'(in_ready), 64'(!pend));
    chk("busy", 64'(busy), 64'(pend));
    chk("wb_valid", 64'(wb_valid), 64'(pend));
    chk("wb_sel", 64'(wb_sel), pend ? 64'(q[0].sel) : 64'd0);
    chk("wb_data", 64'(wb_data), pend ? 64'(q[0].data) : 64'd0);
  endtask

  task automatic step(input logic c, input logic zi,
                      input logic [11:0] op, input logic [63:0] res,
                      input logic zl, input logic zh,
                      input logic wr);
    beat_t b;
    clr = c; Zin = zi; ctrl_signal = op; operationResult = res;
    ZLowout = zl; ZHighout = zh; wb_ready = wr;
    if (c) begin
      q.delete();
      m_z = 64'd0; m_zf = 1'b0; m_nf = 1'b0;
    end else if (q.size() != 0) begin
      if (wr) void'(q.pop_front());
    end else if (zi) begin
      m_z = res;
      if (op == 12'h004) begin
        m_zf = (res == 64'd0);
        m_nf = res[63];
      end else begin
        m_zf = (res[31:0] == 32'd0);
        m_nf = res[31];
      end
      if (op == 12'h004 || op == 12'h008) begin
        b.sel = 1'b0; b.data = res[31:0];  q.push_back(b);
        b.sel = 1'b1; b.data = res[63:32]; q.push_back(b);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] rhalf();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(3) == 0) v = 32'd0;
    return v;
  endfunction

  function automatic logic [11:0] rop();
    logic [11:0] v;
    case ($urandom_range(6))
      0: v = 12'h004;
      1: v = 12'h008;
      2: v = 12'h00C;
      3: v = 12'h000;
      4: v = 12'h001 << $urandom_range(11);
      5: v = 12'h001;
      default: v = 12'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    errors = 0; checks = 0;
    m_z = 64'd0; m_zf = 1'b0; m_nf = 1'b0;
    step(1, 0, 12'h000, 64'd0, 1, 0, 0);
    step(0, 1, 12'h001, 64'h0000_0000_8000_0005, 1, 0, 0);
    step(0, 1, 12'h004, 64'h0000_0001_0000_0000, 0, 1, 1);
    step(0, 0, 12'h000, 64'd0, 0, 1, 1);
    step(0, 0, 12'h000, 64'd0, 0, 1, 1);
    step(0, 1, 12'h008, {32'd3, 32'd0}, 1, 0, 0);
    step(0, 0, 12'h000, 64'd0, 1, 0, 0);
    step(0, 1, 12'h001, 64'h1234_5678_9ABC_DEF0, 1, 0, 0);
    step(0, 0, 12'h000, 64'd0, 0, 1, 0);
    step(0, 0, 12'h000, 64'd0, 0, 1, 1);
    step(0, 0, 12'h000, 64'd0, 0, 1, 1);
    step(0, 1, 12'h00C, 64'hFFFF_FFFF_0000_0001, 0, 1, 1);
    step(0, 1, 12'h004, 64'h8000_0000_0000_0000, 0, 1, 1);
    step(0, 0, 12'h000, 64'd0, 0, 1, 1);
    step(1, 1, 12'h001, 64'd7, 0, 1, 1);
    step(0, 1, 12'h002, 64'hAAAA_AAAA_5555_5555, 1, 1, 0);
    step(0, 0, 12'h000, 64'd0, 0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(40) == 0, $urandom_range(2) != 0, rop(),
           {rhalf(), rhalf()}, 1'($urandom), 1'($urandom),
           $urandom_range(2) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Result stage directly downstream of the ALU. It captures the 2·BITS-wide ALU result into the Z register on the Zin strobe and computes zero/negative flags. It drives either Z half onto the datapath bus on request. For multiply and divide results, it sequences a two-beat LO-then-HI writeback to the HI/LO registers over a valid/ready handshake.

## Interface
- BITS, 32, datapath word width
- SIG_COUNT, 12, width of the one-hot ALU op select (bit 2 = multiply, bit 3 = divide)

- clk  in  1  clock, rising edge
- clr  in  1  synchronous active-high reset
- ctrl_signal  in  SIG_COUNT  one-hot ALU op of the result being captured
- operationResult  in  2·BITS  ALU result
- Zin  in  1  capture strobe
- in_ready  out  1  stage accepts a capture this cycle
- ZLowout  in  1  drive Z[BITS-1:0] on bus_out
- ZHighout  in  1  drive Z[2·BITS-1:BITS] on bus_out
- bus_out  out  BITS  bus drive value
- zero_flag  out  1  captured result is zero
- neg_flag  out  1  captured result is negative
- wb_valid  out  1  writeback beat offered
- wb_ready  in  1  HI/LO register file accepts beat
- wb_sel  out  1  0 = LO beat, 1 = HI beat
- wb_data  out  BITS  writeback data
- busy  out  1  writeback in progress

## Operation
- States: IDLE, HOLD, WB_LO, WB_HI.
- in_ready = 1 in IDLE and HOLD; 0 in WB_LO and WB_HI.
- Capture: when Zin && in_ready, on the clock edge:
  - Z <= operationResult; flags are registered.
  - A new capture in HOLD overwrites Z.
- wide = (ctrl_signal == 1<<2) || (ctrl_signal == 1<<3), exact match only. Zero, multi-hot or any other op value gives wide = 0.
- Next state after capture: WB_LO if wide, else HOLD.
- WB_LO: wb_valid = 1, wb_sel = 0, wb_data = Z[BITS-1:0]. On wb_ready go to WB_HI.
- WB_HI: wb_valid = 1, wb_sel = 1, wb_data = Z[2·BITS-1:BITS]. On wb_ready go to HOLD.
- Zin is ignored during WB_LO and WB_HI; Z and the flags do not change.
- In IDLE and HOLD: wb_valid = 0 and wb_data = 0.
- Flags for a non-wide op: zero_flag = (operationResult[BITS-1:0] == 0), neg_flag = operationResult[BITS-1].
- Flags for multiply: zero_flag = (full 2·BITS == 0), neg_flag = operationResult[2·BITS-1].
- Flags for divide (low half = quotient, high half = remainder): zero_flag = (quotient == 0), neg_flag = operationResult[BITS-1].
- bus_out is combinational from Z:
  - ZLowout selects the low half; ZHighout selects the high half.
  - If both are asserted, ZLowout wins.
  - If neither is asserted, bus_out = 0.
  - Bus reads are legal in every state.
- busy = (state == WB_LO || state == WB_HI).

## Timing
- Reset (clr high at an edge): state IDLE, Z = 0, zero_flag = 0, neg_flag = 0, wb_valid = 0, wb_sel = 0, wb_data = 0, busy = 0, in_ready = 1, bus_out = 0.
- clr mid-writeback aborts immediately, with no further beat. clr has priority over Zin and wb_ready on the same edge.
- Capture latency: Z and the flags are visible on the cycle after the Zin edge.
- Wide ops: wb_valid rises on the cycle after capture.
- Each beat completes on an edge where wb_valid && wb_ready. wb_data and wb_sel hold stable while wb_ready is low.
- Minimum writeback is 2 cycles (wb_ready tied high). in_ready returns on the cycle after the HI beat is accepted.
- Back-to-back captures of non-wide ops are accepted every cycle.

## Test plan
- Reset, then capture: Zin=1, ctrl_signal=12'h001, operationResult=64'h0000_0000_8000_0005 → next cycle ZLowout gives bus_out=32'h8000_0005, neg_flag=1, zero_flag=0, state HOLD, wb_valid=0.
- Multiply with wb_ready tied high: ctrl_signal=12'h004, result 64'h0000_0001_0000_0000 → beat LO (sel 0, data 0), then beat HI (sel 1, data 1) on consecutive cycles; zero_flag=0; in_ready returns afterwards.
- Divide with backpressure: ctrl_signal=12'h008, result {32'd3, 32'd0}, wb_ready low for 3 cycles → LO beat is held stable; zero_flag=1; a Zin pulse during the stall leaves Z unchanged.
- Multi-hot op: ctrl_signal=12'h00C → treated as non-wide; no writeback.
- clr asserted during WB_HI → next cycle wb_valid=0, Z=0, state IDLE.
- ZLowout and ZHighout both high with Z=64'hAAAA_AAAA_5555_5555 → bus_out=32'h5555_5555.
